// File: rtl/arp_reply_sched_pkg.sv
// arp_reply_sched_pkg: ARP/Ethernet frame types and constants, plus the reply builder.
// Revision: 1.0
`default_nettype none
package arp_reply_sched_pkg;

  localparam int          lp_ARP_FRM_SZ     = 42;
  localparam int          lp_ETH_MIN_FRM_SZ = 60;
  localparam logic [15:0] lp_ETHTYPE_ARP    = 16'h0806;
  localparam logic [15:0] lp_ARP_OPER_REPLY = 16'd2;

  // Declared in wire order, so the MSB byte of the packed struct is the first byte sent
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } ether_arp_frame_t;

  function automatic ether_arp_frame_t build_arp_reply(input ether_arp_frame_t req,
                                                       input logic [47:0]      hw,
                                                       input logic [31:0]      ip);
    ether_arp_frame_t rep;
    rep.dst_mac  = req.sha;
    rep.src_mac  = hw;
    rep.eth_type = lp_ETHTYPE_ARP;
    rep.htype    = 16'd1;
    rep.ptype    = 16'h0800;
    rep.hlen     = 8'd6;
    rep.plen     = 8'd4;
    rep.oper     = lp_ARP_OPER_REPLY;
    rep.sha      = hw;
    rep.spa      = ip;
    rep.tha      = req.sha;
    rep.tpa      = req.spa;
    return rep;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arp_reply_sched_if.sv
// arp_reply_sched_if: byte-wide MAC TX valid/ready bus.
// Revision: 1.0
`default_nettype none
interface arp_reply_sched_if;
  logic [7:0] mac_data_o;
  logic       mac_valid_o;
  logic       mac_ready_i;

  modport master (output mac_data_o, output mac_valid_o, input mac_ready_i);
  modport slave  (input mac_data_o, input mac_valid_o, output mac_ready_i);
endinterface
`default_nettype wire

// File: rtl/arp_sched_fifo.sv
// arp_sched_fifo: synchronous first-word-fall-through FIFO for queued ARP requests.
// Revision: 1.0
`default_nettype none
module arp_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   push,
  input  wire logic                   pop,
  input  wire logic [WIDTH-1:0]       din,
  output      logic [WIDTH-1:0]       dout,
  output      logic                   full,
  output      logic                   empty,
  output      logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = pop && !empty;
  // A write into a full FIFO is legal when the head leaves on the same edge
  assign do_wr = push && (!full || do_rd);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/arp_reply_sched.sv
// arp_reply_sched: queues ARP requests and serialises replies MSB-first to the MAC with an IFG.
// Optional ARP_SCHED_PAD_EN pads each reply to the 60-byte Ethernet minimum. Revision: 1.0
`default_nettype none
module arp_reply_sched
  import arp_reply_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int IFG_CYCLES = 12
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [47:0]      hw_addr_i,
  input  wire logic [31:0]      ip_addr_i,
  input  wire ether_arp_frame_t arp_pkt_i,
  input  wire logic             arp_pkt_valid_i,
  arp_reply_sched_if.master     mac_tx,
  output      logic             busy_o,
  output      logic [15:0]      drop_cnt_o
);
`ifdef ARP_SCHED_PAD_EN
  localparam int FRM_LEN = lp_ETH_MIN_FRM_SZ;
`else
  localparam int FRM_LEN = lp_ARP_FRM_SZ;
`endif
  localparam int SR_W  = FRM_LEN * 8;
  localparam int REQ_W = $bits(ether_arp_frame_t);
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_IFG  = 2'd3
  } sched_state_t;

  sched_state_t     state;
  sched_state_t     state_nxt;
  logic [SR_W-1:0]  shift_reg;
  logic [SR_W-1:0]  load_val;
  logic [6:0]       byte_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [REQ_W-1:0] fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             drop;
  logic             accept;
  logic             last_byte;
  ether_arp_frame_t reply;

  assign pop       = (state == ST_LOAD);
  assign push      = arp_pkt_valid_i && (!fifo_full || pop);
  assign drop      = arp_pkt_valid_i && !push;
  assign accept    = (state == ST_SEND) && mac_tx.mac_ready_i;
  assign last_byte = (byte_cnt == 7'(FRM_LEN - 1));
  assign reply     = build_arp_reply(ether_arp_frame_t'(fifo_dout), hw_addr_i, ip_addr_i);

`ifdef ARP_SCHED_PAD_EN
  // Pad bytes are zeros trailing the ARP payload and shift out within the same burst
  assign load_val = {reply, {(SR_W - REQ_W){1'b0}}};
`else
  assign load_val = reply;
`endif

  arp_sched_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (arp_pkt_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // A same-cycle strobe goes straight to LOAD; the entry lands in the FIFO on this edge
      ST_IDLE: if (fifo_count != '0 || arp_pkt_valid_i) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: if (accept && last_byte) state_nxt = ST_IFG;
      ST_IFG:  if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mac_tx.mac_valid_o = (state == ST_SEND);
    mac_tx.mac_data_o  = (state == ST_SEND) ? shift_reg[SR_W-1 -: 8] : 8'h00;
    busy_o             = !fifo_empty || (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      drop_cnt_o <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          shift_reg <= load_val;
          byte_cnt  <= '0;
        end
        ST_SEND: if (accept) begin
          shift_reg <= {shift_reg[SR_W-9:0], 8'h00};
          byte_cnt  <= byte_cnt + 7'd1;
          gap_cnt   <= '0;
        end
        ST_IFG:  gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
      if (drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_arp_reply_sched.sv
// tb_arp_reply_sched: scoreboard bench for arp_reply_sched (define ARP_SCHED_PAD_EN for padded build).
// Revision: 1.0
`default_nettype none
module tb_arp_reply_sched;
  import arp_reply_sched_pkg::*;

`ifdef ARP_SCHED_PAD_EN
  localparam int FRM_LEN = 60;
`else
  localparam int FRM_LEN = 42;
`endif
  localparam int IFG = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [47:0]      hw  = 48'h02_00_00_00_00_01;
  logic [31:0]      ip  = 32'h0A_00_00_01;
  ether_arp_frame_t pkt = '0;
  logic             pkt_valid = 1'b0;
  logic [15:0]      drop_cnt;
  logic             busy;

  arp_reply_sched_if mac_tx();

  arp_reply_sched #(.FIFO_DEPTH(4), .IFG_CYCLES(IFG)) dut (
    .clk             (clk),
    .rst             (rst),
    .hw_addr_i       (hw),
    .ip_addr_i       (ip),
    .arp_pkt_i       (pkt),
    .arp_pkt_valid_i (pkt_valid),
    .mac_tx          (mac_tx),
    .busy_o          (busy),
    .drop_cnt_o      (drop_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  int         gap_q[$];
  int         mon_idx = 0;
  int         frame_cyc = 0;
  int         last_frame_cyc = 0;
  int         frames_done = 0;
  int         gap_run = 0;
  bit         in_frame = 0;
  bit         have_prev = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference reply bytes in wire order, built field by field from the request
  task automatic push_exp(input logic [47:0] sha, input logic [31:0] spa,
                          input logic [47:0] h, input logic [31:0] a);
    logic [7:0] fixed [10];
    fixed = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
    for (int i = 5; i >= 0; i--) exp_q.push_back(sha[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(h[i*8 +: 8]);
    for (int i = 0; i < 10; i++) exp_q.push_back(fixed[i]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(h[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(a[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(sha[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(spa[i*8 +: 8]);
    for (int i = 42; i < FRM_LEN; i++) exp_q.push_back(8'h00);
  endtask

  // Called at posedge+1; strobe is sampled on the next edge and released right after it
  task automatic send_req(input logic [47:0] sha, input logic [31:0] spa, input bit accepted);
    pkt.dst_mac  = 48'hFF_FF_FF_FF_FF_FF;
    pkt.src_mac  = sha;
    pkt.eth_type = 16'h0806;
    pkt.htype    = 16'd1;
    pkt.ptype    = 16'h0800;
    pkt.hlen     = 8'd6;
    pkt.plen     = 8'd4;
    pkt.oper     = 16'd1;
    pkt.sha      = sha;
    pkt.spa      = spa;
    pkt.tha      = 48'hDE_AD_BE_EF_00_00;
    pkt.tpa      = ip;
    pkt_valid    = 1'b1;
    if (accepted) push_exp(sha, spa, hw, ip);
    @(posedge clk); #1;
    pkt_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget = 3000;
    while ((exp_q.size() != 0 || busy || in_frame) && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    if (budget == 0) check_val({tag, "_drain_timeout"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_frame   = 0;
      mon_idx    = 0;
      have_prev  = 0;
      prev_stall = 0;
      gap_run    = 0;
    end else if (mac_tx.mac_valid_o) begin
      if (prev_stall) check_val("stall_hold", mac_tx.mac_data_o, prev_data);
      if (!in_frame) begin
        in_frame  = 1;
        frame_cyc = 0;
        mon_idx   = 0;
        if (have_prev) gap_q.push_back(gap_run);
      end
      frame_cyc++;
      if (mac_tx.mac_ready_i) begin
        if (exp_q.size() == 0) check_val("sb_underflow", exp_q.size(), 1);
        else check_val($sformatf("byte%0d", mon_idx), mac_tx.mac_data_o, exp_q.pop_front());
        mon_idx++;
        if (mon_idx == FRM_LEN) begin
          in_frame       = 0;
          frames_done++;
          last_frame_cyc = frame_cyc;
          have_prev      = 1;
          gap_run        = 0;
        end
      end
      prev_stall = !mac_tx.mac_ready_i;
      prev_data  = mac_tx.mac_data_o;
    end else begin
      if (in_frame) begin
        check_val("valid_drop", mac_tx.mac_valid_o, 1);
        in_frame = 0;
      end
      gap_run++;
      prev_stall = 0;
    end
  end

  initial begin
    int f0;
    int base;
    int budget;
    mac_tx.mac_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_valid", mac_tx.mac_valid_o, 0);
    check_val("rst_data", mac_tx.mac_data_o, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_drop", drop_cnt, 0);

    // Single request; local address changes mid-frame must not leak into it
    f0 = frames_done;
    send_req(48'h02_00_00_00_00_02, 32'h0A_00_00_02, 1);
    check_val("lat1_valid", mac_tx.mac_valid_o, 0);
    @(posedge clk); #1;
    check_val("lat2_valid", mac_tx.mac_valid_o, 1);
    hw = 48'h02_00_00_00_00_99;
    ip = 32'h0A_00_00_63;
    drain("single");
    hw = 48'h02_00_00_00_00_01;
    ip = 32'h0A_00_00_01;
    check_val("single_frames", frames_done - f0, 1);
    check_val("single_cycles", last_frame_cyc, FRM_LEN);

    // Backpressure: ready alternates, starting low on the first valid cycle
    f0 = frames_done;
    mac_tx.mac_ready_i = 1'b0;
    send_req(48'h02_00_00_00_00_0B, 32'h0A_00_00_0B, 1);
    mac_tx.mac_ready_i = 1'b1;
    budget = 500;
    while (frames_done == f0 && budget > 0) begin
      @(posedge clk); #1;
      mac_tx.mac_ready_i = ~mac_tx.mac_ready_i;
      budget--;
    end
    mac_tx.mac_ready_i = 1'b1;
    drain("bp");
    check_val("bp_frames", frames_done - f0, 1);
    check_val("bp_cycles", last_frame_cyc, 2 * FRM_LEN);

    // Back-to-back: low interval is IFG plus the IDLE and LOAD cycles
    f0   = frames_done;
    base = gap_q.size();
    send_req(48'h02_00_00_00_00_03, 32'h0A_00_00_03, 1);
    send_req(48'h02_00_00_00_00_04, 32'h0A_00_00_04, 1);
    send_req(48'h02_00_00_00_00_05, 32'h0A_00_00_05, 1);
    drain("b2b");
    check_val("b2b_frames", frames_done - f0, 3);
    check_val("b2b_gap_cnt", gap_q.size() - base, 3);
    if (gap_q.size() - base == 3) begin
      check_val("b2b_gap1", gap_q[base+1], IFG + 2);
      check_val("b2b_gap2", gap_q[base+2], IFG + 2);
    end

    // Overflow: one in flight, four queued, sixth dropped
    f0 = frames_done;
    mac_tx.mac_ready_i = 1'b0;
    for (int i = 0; i < 6; i++)
      send_req(48'h02_00_00_00_01_00 + 48'(i), 32'h0A_00_01_00 + 32'(i), i < 5);
    @(posedge clk); #1;
    check_val("ovf_drop", drop_cnt, 1);
    check_val("ovf_busy", busy, 1);
    check_val("ovf_held", mac_tx.mac_valid_o, 1);
    mac_tx.mac_ready_i = 1'b1;
    drain("ovf");
    check_val("ovf_frames", frames_done - f0, 5);
    check_val("ovf_drop_end", drop_cnt, 1);

    // Reset mid-frame abandons it, then a fresh frame is complete
    send_req(48'h02_00_00_00_00_07, 32'h0A_00_00_07, 1);
    budget = 200;
    while (!(in_frame && mon_idx == 20) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_val("rst_reach_b20", mon_idx, 20);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_val("mrst_valid", mac_tx.mac_valid_o, 0);
    check_val("mrst_data", mac_tx.mac_data_o, 0);
    check_val("mrst_busy", busy, 0);
    check_val("mrst_drop", drop_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    f0 = frames_done;
    send_req(48'h02_00_00_00_00_08, 32'h0A_00_00_08, 1);
    drain("post_rst");
    check_val("post_rst_frames", frames_done - f0, 1);
    check_val("post_rst_cycles", last_frame_cyc, FRM_LEN);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
